// File: rtl/vga_pkg.sv
// Shared types for the VGA capture path: pixel format, capture FSM states
// and the packed beat that travels through the output buffer.
package vga_pkg;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOF = 2'd1,
      ACTIVE   = 2'd2,
      DROP     = 2'd3
   } vga_cap_state_e;

   typedef struct packed {
      logic    tuser;
      logic    tlast;
      rgb565_t data;
   } vga_beat_t;

   localparam int BEAT_W = $bits(vga_beat_t);

endpackage

// File: rtl/axi4s_if.sv
// Minimal AXI4-Stream bundle (no tkeep/tstrb/tid/tdest).
interface axi4s_if #(
   parameter int DATA_WIDTH = 16,
   parameter int USER_WIDTH = 1
);
   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic [USER_WIDTH-1:0] tuser;
   logic                  tlast;

   modport master (output tvalid, tdata, tuser, tlast, input tready);
   modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra pointer MSB for full/empty; read data is
// forced to zero while empty so the stream bus idles at zero.
module sync_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             do_wr;
   logic             do_rd;

   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_wr     = wr_en_i && !full_o;
   assign do_rd     = rd_en_i && !empty_o;
   assign rd_data_o = empty_o ? '0 : mem[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
   end

endmodule

// File: rtl/vga_to_axis.sv
// Captures DE/VS-framed RGB565 video into an AXI4-Stream with SOF on tuser
// and EOL on tlast; malformed or overflowing frames are dropped until next VS.
import vga_pkg::*;

module vga_to_axis #(
   parameter int H_RES      = 800,
   parameter int V_RES      = 600,
   parameter int FIFO_DEPTH = 16
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           enable_i,
   input  rgb565_t        vid_data_i,
   input  logic           vid_de_i,
   input  logic           vid_vs_i,
   axi4s_if.master        m_axis,
   input  logic           clr_i,
   output logic           err_ovf_o,
   output logic           err_line_o,
   output logic [15:0]    frame_cnt_o
);
   localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

   rgb565_t        data_p0;
   logic           de_p0, vs_p0, de_p1, vs_p1;
   logic           vs_rise, de_fall;

   vga_cap_state_e state_q, state_d;
   logic [XW-1:0]  x_q, x_d;
   logic [YW-1:0]  y_q, y_d;
   logic           wrapped_q, wrapped_d;
   logic           wr_en, set_ovf, set_line, frame_done;

   vga_beat_t      wr_beat, rd_beat;
   logic           fifo_full, fifo_empty;

   // stage p0: registered video inputs, p1: delayed copy for edge detection
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         de_p0 <= 1'b0;
         vs_p0 <= 1'b0;
         de_p1 <= 1'b0;
         vs_p1 <= 1'b0;
      end else begin
         de_p0 <= vid_de_i;
         vs_p0 <= vid_vs_i;
         de_p1 <= de_p0;
         vs_p1 <= vs_p0;
      end
   end

   always_ff @(posedge clk_i) begin
      data_p0 <= vid_data_i;
   end

   assign vs_rise = vs_p0 && !vs_p1;
   assign de_fall = de_p1 && !de_p0;

   // wrapped marks a line completed inside the current DE burst; any further
   // DE in that burst means the line is longer than H_RES
   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      wrapped_d  = wrapped_q && de_p0;
      wr_en      = 1'b0;
      set_ovf    = 1'b0;
      set_line   = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable_i) state_d = WAIT_SOF;
         end
         WAIT_SOF: begin
            if (!enable_i) begin
               state_d = IDLE;
            end else if (vs_rise) begin
               state_d   = ACTIVE;
               x_d       = '0;
               y_d       = '0;
               wrapped_d = 1'b0;
            end
         end
         ACTIVE: begin
            if (vs_rise) begin
               set_line  = 1'b1;
               x_d       = '0;
               y_d       = '0;
               wrapped_d = 1'b0;
            end else if ((de_fall && x_q != '0) || (de_p0 && wrapped_q)) begin
               set_line = 1'b1;
               state_d  = DROP;
            end else if (de_p0) begin
               if (fifo_full) begin
                  set_ovf = 1'b1;
                  state_d = DROP;
               end else begin
                  wr_en = 1'b1;
                  if (x_q == X_LAST) begin
                     x_d       = '0;
                     wrapped_d = 1'b1;
                     if (y_q == Y_LAST) begin
                        y_d        = '0;
                        frame_done = 1'b1;
                        state_d    = enable_i ? WAIT_SOF : IDLE;
                     end else begin
                        y_d = y_q + YW'(1);
                     end
                  end else begin
                     x_d = x_q + XW'(1);
                  end
               end
            end
         end
         DROP: begin
            if (!enable_i)    state_d = IDLE;
            else if (vs_rise) state_d = WAIT_SOF;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         wrapped_q   <= 1'b0;
         err_ovf_o   <= 1'b0;
         err_line_o  <= 1'b0;
         frame_cnt_o <= '0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         wrapped_q  <= wrapped_d;
         err_ovf_o  <= set_ovf  || (err_ovf_o  && !clr_i);
         err_line_o <= set_line || (err_line_o && !clr_i);
         if (frame_done) frame_cnt_o <= frame_cnt_o + 16'd1;
      end
   end

   assign wr_beat.tuser = (x_q == '0) && (y_q == '0);
   assign wr_beat.tlast = (x_q == X_LAST);
   assign wr_beat.data  = data_p0;

   sync_fifo #(
      .WIDTH (BEAT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wr_en_i   (wr_en),
      .wr_data_i (wr_beat),
      .rd_en_i   (m_axis.tvalid && m_axis.tready),
      .rd_data_o (rd_beat),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign m_axis.tvalid = !fifo_empty;
   assign m_axis.tdata  = rd_beat.data;
   assign m_axis.tuser  = rd_beat.tuser;
   assign m_axis.tlast  = rd_beat.tlast;

endmodule

// File: tb/tb_vga_to_axis.sv
// Directed bench for vga_to_axis at H_RES=8, V_RES=4, FIFO_DEPTH=16.
module tb_vga_to_axis;
   import vga_pkg::*;

   localparam int H = 8;
   localparam int V = 4;
   localparam int D = 16;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        enable = 1'b1;
   logic        vde    = 1'b0;
   logic        vvs    = 1'b0;
   logic        clr    = 1'b0;
   rgb565_t     vdata  = '0;
   logic        ovf;
   logic        lerr;
   logic [15:0] fc;

   int total = 0;
   int bad   = 0;
   int pcount = 0;
   int clr_pix = -1;
   logic [17:0] beats[$];

   typedef struct {
      string name;
      int    ready;
      int    bad_line;
      int    bad_len;
      int    exp_beats;
      int    exp_ovf;
      int    exp_line;
      int    exp_fc;
   } vec_t;
   vec_t vecs[5];

   axi4s_if #(.DATA_WIDTH(16), .USER_WIDTH(1)) axis ();

   vga_to_axis #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(D)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .enable_i    (enable),
      .vid_data_i  (vdata),
      .vid_de_i    (vde),
      .vid_vs_i    (vvs),
      .m_axis      (axis),
      .clr_i       (clr),
      .err_ovf_o   (ovf),
      .err_line_o  (lerr),
      .frame_cnt_o (fc)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && axis.tvalid && axis.tready)
         beats.push_back({axis.tuser[0], axis.tlast, axis.tdata});
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   function automatic logic [15:0] pix(int y, int x);
      return 16'(((y + 1) << 12) | ((x + 1) << 4) | 5);
   endfunction

   function automatic logic [17:0] exp_beat(int k);
      int y = k / H;
      int x = k % H;
      return {(k == 0), (x == H - 1), pix(y, x)};
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_vs();
      vvs = 1'b1;
      tick(); tick();
      vvs = 1'b0;
      tick(); tick();
   endtask

   task automatic send_line(int l, int len);
      for (int p = 0; p < len; p++) begin
         vde   = 1'b1;
         vdata = pix(l, p);
         tick();
         clr = (pcount == clr_pix);
         pcount++;
      end
      vde = 1'b0;
      tick();
      clr = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic send_frame(int bad_line, int bad_len);
      pcount = 0;
      send_vs();
      for (int l = 0; l < V; l++) send_line(l, (l == bad_line) ? bad_len : H);
   endtask

   task automatic drain();
      axis.tready = 1'b1;
      repeat (40) tick();
   endtask

   task automatic do_reset();
      vde   = 1'b0;
      vvs   = 1'b0;
      clr   = 1'b0;
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic check_beats(string nm, int n, int restart);
      int badk = -1;
      chk({nm, ".beats"}, beats.size(), n);
      for (int k = 0; k < beats.size() && k < n; k++) begin
         int kk = (k >= restart) ? k - restart : k;
         if (badk < 0 && beats[k] !== exp_beat(kk)) badk = k;
      end
      chk({nm, ".pattern_first_bad"}, badk, -1);
   endtask

   initial begin
      vecs[0] = '{"clean",  1, -1,  8, 32, 0, 0, 1};
      vecs[1] = '{"ovf",    0, -1,  8, 16, 1, 0, 0};
      vecs[2] = '{"short1", 1,  1,  5, 13, 0, 1, 0};
      vecs[3] = '{"long0",  1,  0, 10,  8, 0, 1, 0};
      vecs[4] = '{"short2", 1,  2,  6, 22, 0, 1, 0};

      axis.tready = 1'b1;
      tick(); tick();
      chk("rst.tvalid", axis.tvalid, 0);
      chk("rst.tdata",  axis.tdata, 0);
      chk("rst.tuser",  axis.tuser, 0);
      chk("rst.tlast",  axis.tlast, 0);
      chk("rst.ovf",    ovf, 0);
      chk("rst.line",   lerr, 0);
      chk("rst.fc",     fc, 0);

      // table-driven single-frame scenarios, each from a fresh reset
      for (int i = 0; i < 5; i++) begin
         do_reset();
         beats.delete();
         axis.tready = vecs[i].ready[0];
         send_frame(vecs[i].bad_line, vecs[i].bad_len);
         drain();
         check_beats(vecs[i].name, vecs[i].exp_beats, 1000);
         chk({vecs[i].name, ".ovf"},  ovf,  vecs[i].exp_ovf);
         chk({vecs[i].name, ".line"}, lerr, vecs[i].exp_line);
         chk({vecs[i].name, ".fc"},   fc,   vecs[i].exp_fc);
      end

      // latency: pixel driven after edge k is visible on tvalid after edge k+2
      do_reset();
      axis.tready = 1'b0;
      send_vs();
      vde   = 1'b1;
      vdata = pix(0, 0);
      tick();
      vde = 1'b0;
      @(negedge clk);
      chk("lat.k1_tvalid", axis.tvalid, 0);
      @(negedge clk);
      chk("lat.k2_tvalid", axis.tvalid, 1);
      chk("lat.tuser", axis.tuser, 1);
      chk("lat.tdata", axis.tdata, pix(0, 0));
      tick();

      // overflow with coincident clear, head held under backpressure, recovery
      do_reset();
      beats.delete();
      axis.tready = 1'b0;
      clr_pix = 16;
      send_frame(-1, H);
      clr_pix = -1;
      chk("ovfclr.ovf_kept", ovf, 1);
      chk("ovfclr.state",    dut.state_q, DROP);
      chk("ovfclr.hold_data", axis.tdata, pix(0, 0));
      chk("ovfclr.hold_user", axis.tuser, 1);
      chk("ovfclr.fc",       fc, 0);
      drain();
      beats.delete();
      send_vs();
      send_frame(-1, H);
      drain();
      check_beats("recover", 32, 1000);
      chk("recover.fc",  fc, 1);
      chk("recover.ovf_sticky", ovf, 1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tick();
      chk("clr_alone.ovf", ovf, 0);

      // early VS after two lines restarts as a new frame
      do_reset();
      beats.delete();
      axis.tready = 1'b1;
      send_vs();
      send_line(0, H);
      send_line(1, H);
      send_frame(-1, H);
      drain();
      chk("early.line", lerr, 1);
      check_beats("early", 48, 16);
      if (beats.size() > 16) chk("early.sof_user", beats[16][17], 1);
      else chk("early.sof_present", beats.size(), 17);
      chk("early.fc", fc, 1);

      // capture disabled: nothing is accepted
      enable = 1'b0;
      do_reset();
      beats.delete();
      send_frame(-1, H);
      drain();
      chk("disabled.beats", beats.size(), 0);
      chk("disabled.fc", fc, 0);
      enable = 1'b1;

      // reset mid-line aborts; output only resumes after a new VS
      do_reset();
      axis.tready = 1'b1;
      send_vs();
      for (int p = 0; p < 4; p++) begin
         vde   = 1'b1;
         vdata = pix(0, p);
         tick();
      end
      rst_n = 1'b0;
      #1;
      chk("midrst.tvalid", axis.tvalid, 0);
      tick();
      rst_n = 1'b1;
      beats.delete();
      for (int p = 4; p < H; p++) begin
         vdata = pix(0, p);
         tick();
      end
      vde = 1'b0;
      send_line(1, H);
      send_line(2, H);
      drain();
      chk("midrst.no_output", beats.size(), 0);
      send_frame(-1, H);
      drain();
      check_beats("midrst.resume", 32, 1000);
      chk("midrst.fc", fc, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_to_axis.md
VGA_TO_AXIS -- requirements
Module: vga_to_axis

Interface
REQ-001 SHALL have parameter H_RES, default 800, meaning active pixels per line.
REQ-002 SHALL have parameter V_RES, default 600, meaning active lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning output buffer entries (power of two, >=4).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk_i  input  1  sole clock; rst_ni  input  1  async active-low reset.
REQ-005 SHALL have port enable_i  input  1  capture enable, sampled at frame boundaries.
REQ-006 SHALL have port vid_data_i  input  16  rgb565_t pixel.
REQ-007 SHALL have port vid_de_i  input  1  data enable, active-high.
REQ-008 SHALL have port vid_vs_i  input  1  vertical sync, active-high level.
REQ-009 SHALL have port m_axis  modport  axi4s_if.master (DATA_WIDTH 16, USER_WIDTH 1)  output stream: tdata pixel, tuser start-of-frame, tlast end-of-line.
REQ-010 SHALL have port clr_i  input  1  single-cycle pulse clearing sticky errors.
REQ-011 SHALL have port err_ovf_o  output  1  sticky FIFO overflow flag.
REQ-012 SHALL have port err_line_o  output  1  sticky line-length mismatch flag.
REQ-013 SHALL have port frame_cnt_o  output  16  count of frames completed without error, wraps 0xFFFF->0.

Function
REQ-014 SHALL register vid_* inputs once; vs rising edge is detected on the registered copy.
REQ-015 SHALL implement FSM states IDLE, WAIT_SOF, ACTIVE, DROP.
REQ-016 IDLE -> WAIT_SOF when enable_i=1; any state except ACTIVE -> IDLE when enable_i=0; ACTIVE -> IDLE only after frame end.
REQ-017 WAIT_SOF -> ACTIVE on vs rising edge; x and y counters cleared; no pixels accepted in WAIT_SOF/IDLE/DROP.
REQ-018 In ACTIVE, each registered de=1 cycle SHALL write {tuser,tlast,data} to the FIFO; tuser=1 only for x=0,y=0; tlast=1 only for x=H_RES-1.
REQ-019 x SHALL increment per accepted pixel and wrap to 0 after H_RES-1, incrementing y; after y=V_RES-1 line completes, frame_cnt_o increments and FSM -> WAIT_SOF.
REQ-020 de falling with x!=0, or de=1 with x wrapped and same de burst continuing, SHALL set err_line_o and go to DROP.
REQ-021 Write attempt with FIFO full SHALL discard the pixel, set err_ovf_o, go to DROP.
REQ-022 DROP SHALL discard all input and -> WAIT_SOF on next vs rising edge; FIFO entries already written still drain; frame_cnt_o not incremented.
REQ-023 vs rising edge while ACTIVE (early frame) SHALL set err_line_o and restart as a new SOF in the same cycle.
REQ-024 m_axis.tvalid SHALL equal FIFO non-empty; a beat pops on tvalid&tready; tdata/tuser/tlast stable while tvalid&!tready.
REQ-025 Latency: pixel on vid_* at edge k SHALL appear on tvalid after edge k+2 when FIFO empty; sustained 1 beat/cycle with tready=1.
REQ-026 clr_i SHALL clear both error flags next cycle; a new error in the same cycle as clr_i wins (flag stays 1).

Reset
REQ-027 On rst_ni=0: FSM IDLE, counters 0, FIFO empty, tvalid=0, tdata/tuser/tlast=0, err flags 0, frame_cnt_o=0.
REQ-028 Reset asserted mid-frame SHALL abort immediately; after release capture resumes only at a subsequent vs rising edge.

Structure
REQ-029 rgb565_t SHALL come from vga_pkg; capture FSM enum vga_cap_state_e SHALL be added to vga_pkg.
REQ-030 Buffer SHALL be sub-module sync_fifo (single clock, width 18, depth FIFO_DEPTH, full/empty outputs).

Verification (H_RES=8, V_RES=4, FIFO_DEPTH=16)
REQ-031 Clean frame, tready=1 -> 32 beats, tuser on beat 0 only, tlast on beats 7,15,23,31, frame_cnt_o=1, no errors.
REQ-032 tready=0 for whole frame -> first 16 pixels buffered, err_ovf_o=1, FSM DROP; next frame with tready=1 -> 32 clean beats, frame_cnt_o=1.
REQ-033 Line 1 with only 5 de cycles -> err_line_o=1, no further writes until next vs, frame_cnt_o unchanged.
REQ-034 vs rising edge after 2 lines -> err_line_o=1, next accepted pixel carries tuser=1.
REQ-035 clr_i pulse coincident with overflow -> err_ovf_o stays 1; clr_i alone later -> 0.
REQ-036 rst_ni low mid-line then released -> tvalid=0 immediately, output resumes with tuser=1 beat after next vs.
